enigma_ctrl: RTL and testbench
==============================

ENIGMA_CTRL -- requirements
Module: enigma_ctrl

Interface
REQ-001 SHALL have port clk_i input 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i input 1: reset, asynchronous, active-low.
REQ-003 SHALL have port start_i input 1: one-cycle request to process a message; honoured only in IDLE.
REQ-004 SHALL have port abort_i input 1: synchronous abort, any state.
REQ-005 SHALL have port symb_numb_i input 6: message length; sampled on accepted start_i; legal 1..16.
REQ-006 SHALL have ports wrap_i input 6 and in_vld_i input 1: plaintext symbol and its valid.
REQ-007 SHALL have port in_rdy_o output 1: controller accepts wrap_i this cycle.
REQ-008 SHALL have port cfg_load_o output 1: one-cycle pulse telling the core to reload rotor start positions.
REQ-009 SHALL have ports core_req_o output 1 and core_sym_o output 6: symbol offered to the core.
REQ-010 SHALL have ports core_ack_i input 1 and core_sym_i input 6: core completion and encoded symbol.
REQ-011 SHALL have ports wrap_o output 6 and out_vld_o output 1: ciphertext stream.
REQ-012 SHALL have ports busy_o, done_o, err_o output 1 each: not-IDLE level, completion pulse, error pulse.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, CFG, ENC, DRAIN, DONE.
REQ-014 SHALL, in IDLE on start_i with symb_numb_i in 1..16, latch N and go to LOAD next cycle; with 0 or >16, pulse err_o one cycle and stay IDLE.
REQ-015 SHALL in LOAD drive in_rdy_o=1 and write wrap_i into input buffer slot k (k=0..N-1) on each cycle with in_vld_i=1; after the N-th write go to CFG.
REQ-016 SHALL ignore in_vld_i outside LOAD; in_rdy_o=0 outside LOAD.
REQ-017 SHALL in CFG assert cfg_load_o for exactly one cycle, then go to ENC with read index 0.
REQ-018 SHALL in ENC, for a letter symbol (1..26), hold core_req_o=1 and core_sym_o=buffer[i] stable until the cycle core_ack_i=1 is sampled, store core_sym_i in output buffer[i], drop core_req_o next cycle, advance i.
REQ-019 SHALL in ENC, for a non-letter symbol (0 or 27..63), copy it unencoded to output buffer[i] in one cycle without asserting core_req_o.
REQ-020 SHALL ignore core_ack_i while core_req_o=0.
REQ-021 SHALL run an 8-bit watchdog while core_req_o=1; at 255 cycles without ack, pulse err_o, drop core_req_o, return to IDLE.
REQ-022 SHALL after symbol N-1 go to DRAIN and output buffer[0..N-1] on wrap_o, one per cycle, out_vld_o=1, no backpressure; wrap_o=0 when out_vld_o=0.
REQ-023 SHALL in DONE pulse done_o one cycle, then IDLE.
REQ-024 SHALL on abort_i=1 go to IDLE next cycle from any state, clearing indices, core_req_o, out_vld_o; abort wins over start_i in the same cycle; no err_o, no done_o.
REQ-025 SHALL drive busy_o=1 in every state except IDLE.
REQ-026 SHALL keep buffer contents undefined-irrelevant: a new message fully overwrites slots 0..N-1 before they are read.

Reset
REQ-027 SHALL on rst_i=0 immediately enter IDLE, clear N, indices, watchdog, and drive all outputs to 0, including mid-message.
REQ-028 SHALL NOT require buffer storage to be reset.

Structure
REQ-029 SHALL take SYMB_W=6, DEPTH=16, LETTER_MIN=1, LETTER_MAX=26, WDOG_MAX=255 and the FSM state enum from shared package enigma_pkg.
REQ-030 SHALL instantiate sub-module sym_buf (DEPTH x SYMB_W register file, one synchronous write, one combinational read) twice: input and output buffer.

Verification
REQ-031 SHALL test: N=3, symbols 1,2,3, core acks 2 cycles after req with 5,6,7 -> one cfg_load_o, wrap_o 5,6,7 on consecutive cycles, done_o pulse.
REQ-032 SHALL test: N=4, symbols 8,0,27,9 -> core_req_o only for 8 and 9; wrap_o shows encoded, 0, 27, encoded.
REQ-033 SHALL test: start_i with symb_numb_i=0 and =17 -> err_o pulse each, busy_o stays 0.
REQ-034 SHALL test: N=2, core never acks -> err_o 255 cycles after core_req_o rises, then IDLE.
REQ-035 SHALL test: abort_i during ENC and rst_i low during DRAIN -> IDLE, all outputs 0, next N=1 message completes correctly.
REQ-036 SHALL test: N=16 with gaps in in_vld_i -> exactly 16 writes, all 16 symbols output in order.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared constants, FSM state encoding and symbol helpers for the enigma controller.
package enigma_pkg;

    localparam int SYMB_W = 6;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 5;   // must hold 0..DEPTH inclusive

    localparam logic [SYMB_W-1:0] LETTER_MIN = 6'd1;
    localparam logic [SYMB_W-1:0] LETTER_MAX = 6'd26;
    localparam logic [7:0]        WDOG_MAX   = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CFG   = 3'd2,
        ST_ENC   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // A symbol is sent through the rotor core only when it is a letter.
    function automatic logic is_letter(input logic [SYMB_W-1:0] sym);
        return (sym >= LETTER_MIN) && (sym <= LETTER_MAX);
    endfunction

    // Message lengths 1..DEPTH are accepted; anything else is a request error.
    function automatic logic len_ok(input logic [SYMB_W-1:0] n);
        return (n >= 6'd1) && (n <= 6'(DEPTH));
    endfunction

endpackage

// File: rtl/enigma_if.sv
// Host and rotor-core signal bundle of the enigma controller.
// master = host/core side, slave = controller.
interface enigma_if;
    import enigma_pkg::*;

    logic              start_i;
    logic              abort_i;
    logic [SYMB_W-1:0] symb_numb_i;
    logic [SYMB_W-1:0] wrap_i;
    logic              in_vld_i;
    logic              in_rdy_o;
    logic              cfg_load_o;
    logic              core_req_o;
    logic [SYMB_W-1:0] core_sym_o;
    logic              core_ack_i;
    logic [SYMB_W-1:0] core_sym_i;
    logic [SYMB_W-1:0] wrap_o;
    logic              out_vld_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport master (
        output start_i, abort_i, symb_numb_i, wrap_i, in_vld_i, core_ack_i, core_sym_i,
        input  in_rdy_o, cfg_load_o, core_req_o, core_sym_o, wrap_o, out_vld_o,
               busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, abort_i, symb_numb_i, wrap_i, in_vld_i, core_ack_i, core_sym_i,
        output in_rdy_o, cfg_load_o, core_req_o, core_sym_o, wrap_o, out_vld_o,
               busy_o, done_o, err_o
    );

endinterface

// File: rtl/enigma_sym_buf.sv
// Small symbol register file: one synchronous write port, one combinational read port.
// Contents are not reset; every message overwrites its slots before reading them.
module sym_buf
    import enigma_pkg::*;
#(
    parameter int BUF_DEPTH = DEPTH,
    parameter int BUF_W     = SYMB_W,
    localparam int AW       = $clog2(BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [BUF_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [BUF_W-1:0] rdata
);

    logic [BUF_W-1:0] mem [BUF_DEPTH];

    // Storage write; no reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/enigma_ctrl.sv
// Enigma message controller: buffers a plaintext message, feeds letters through the
// rotor core one at a time, passes non-letters straight through, then streams the
// ciphertext out. All interface outputs are registered.
module enigma_ctrl
    import enigma_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    enigma_if.slave   bus
);

    state_t            state_r;
    logic [IDX_W-1:0]  n_r;
    logic [IDX_W-1:0]  idx_r;
    logic [7:0]        wdog_r;

    logic              in_rdy_r;
    logic              cfg_load_r;
    logic              core_req_r;
    logic [SYMB_W-1:0] core_sym_r;
    logic [SYMB_W-1:0] wrap_r;
    logic              out_vld_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic [3:0]        slot_s;
    logic              last_s;
    logic [SYMB_W-1:0] in_rd_s;
    logic [SYMB_W-1:0] out_rd_s;
    logic              in_we_s;
    logic              out_we_s;
    logic [SYMB_W-1:0] out_wd_s;

    // One shared index walks load, encode and drain; each phase restarts it at 0.
    assign slot_s = idx_r[3:0];
    assign last_s = (idx_r == (n_r - 5'd1));

    sym_buf u_in_buf (
        .clk   (clk_i),
        .we    (in_we_s),
        .waddr (slot_s),
        .wdata (bus.wrap_i),
        .raddr (slot_s),
        .rdata (in_rd_s)
    );

    sym_buf u_out_buf (
        .clk   (clk_i),
        .we    (out_we_s),
        .waddr (slot_s),
        .wdata (out_wd_s),
        .raddr (slot_s),
        .rdata (out_rd_s)
    );

    // Buffer write strobes: plaintext during LOAD, core result or pass-through during ENC.
    always_comb begin
        in_we_s  = 1'b0;
        out_we_s = 1'b0;
        out_wd_s = 6'd0;
        if (bus.abort_i) begin
            in_we_s  = 1'b0;
            out_we_s = 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    in_we_s = bus.in_vld_i;
                end
                ST_ENC: begin
                    if (core_req_r) begin
                        out_we_s = bus.core_ack_i;
                        out_wd_s = bus.core_sym_i;
                    end else if (!is_letter(in_rd_s)) begin
                        out_we_s = 1'b1;
                        out_wd_s = in_rd_s;
                    end else begin
                        out_we_s = 1'b0;
                    end
                end
                default: begin
                    in_we_s  = 1'b0;
                    out_we_s = 1'b0;
                end
            endcase
        end
    end

    // Controller FSM with registered outputs; abort has priority over everything.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            n_r        <= 5'd0;
            idx_r      <= 5'd0;
            wdog_r     <= 8'd0;
            in_rdy_r   <= 1'b0;
            cfg_load_r <= 1'b0;
            core_req_r <= 1'b0;
            core_sym_r <= 6'd0;
            wrap_r     <= 6'd0;
            out_vld_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (bus.abort_i) begin
                state_r    <= ST_IDLE;
                idx_r      <= 5'd0;
                wdog_r     <= 8'd0;
                in_rdy_r   <= 1'b0;
                cfg_load_r <= 1'b0;
                core_req_r <= 1'b0;
                core_sym_r <= 6'd0;
                wrap_r     <= 6'd0;
                out_vld_r  <= 1'b0;
                busy_r     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.start_i) begin
                            if (len_ok(bus.symb_numb_i)) begin
                                n_r      <= bus.symb_numb_i[IDX_W-1:0];
                                idx_r    <= 5'd0;
                                state_r  <= ST_LOAD;
                                in_rdy_r <= 1'b1;
                                busy_r   <= 1'b1;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (bus.in_vld_i) begin
                            if (last_s) begin
                                state_r    <= ST_CFG;
                                in_rdy_r   <= 1'b0;
                                cfg_load_r <= 1'b1;
                                idx_r      <= 5'd0;
                            end else begin
                                idx_r <= idx_r + 5'd1;
                            end
                        end
                    end
                    ST_CFG: begin
                        cfg_load_r <= 1'b0;
                        idx_r      <= 5'd0;
                        state_r    <= ST_ENC;
                    end
                    ST_ENC: begin
                        if (core_req_r) begin
                            if (bus.core_ack_i) begin
                                core_req_r <= 1'b0;
                                core_sym_r <= 6'd0;
                                if (last_s) begin
                                    state_r <= ST_DRAIN;
                                    idx_r   <= 5'd0;
                                end else begin
                                    idx_r <= idx_r + 5'd1;
                                end
                            end else if (wdog_r == (WDOG_MAX - 8'd1)) begin
                                // Request has been high for WDOG_MAX cycles on the next one.
                                err_r      <= 1'b1;
                                core_req_r <= 1'b0;
                                core_sym_r <= 6'd0;
                                busy_r     <= 1'b0;
                                idx_r      <= 5'd0;
                                wdog_r     <= 8'd0;
                                state_r    <= ST_IDLE;
                            end else begin
                                wdog_r <= wdog_r + 8'd1;
                            end
                        end else if (is_letter(in_rd_s)) begin
                            core_req_r <= 1'b1;
                            core_sym_r <= in_rd_s;
                            wdog_r     <= 8'd0;
                        end else if (last_s) begin
                            state_r <= ST_DRAIN;
                            idx_r   <= 5'd0;
                        end else begin
                            idx_r <= idx_r + 5'd1;
                        end
                    end
                    ST_DRAIN: begin
                        if (idx_r == n_r) begin
                            out_vld_r <= 1'b0;
                            wrap_r    <= 6'd0;
                            done_r    <= 1'b1;
                            idx_r     <= 5'd0;
                            state_r   <= ST_DONE;
                        end else begin
                            out_vld_r <= 1'b1;
                            wrap_r    <= out_rd_s;
                            idx_r     <= idx_r + 5'd1;
                        end
                    end
                    ST_DONE: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        idx_r      <= 5'd0;
                        wdog_r     <= 8'd0;
                        in_rdy_r   <= 1'b0;
                        cfg_load_r <= 1'b0;
                        core_req_r <= 1'b0;
                        core_sym_r <= 6'd0;
                        wrap_r     <= 6'd0;
                        out_vld_r  <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_rdy_o   = in_rdy_r;
    assign bus.cfg_load_o = cfg_load_r;
    assign bus.core_req_o = core_req_r;
    assign bus.core_sym_o = core_sym_r;
    assign bus.wrap_o     = wrap_r;
    assign bus.out_vld_o  = out_vld_r;
    assign bus.busy_o     = busy_r;
    assign bus.done_o     = done_r;
    assign bus.err_o      = err_r;

endmodule

// File: tb/tb_enigma_ctrl.sv
// Randomized scoreboard bench for enigma_ctrl with a behavioural rotor-core responder.
module tb_enigma_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    enigma_if bus ();

    enigma_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q [$];
    logic [5:0] let_q [$];
    logic [5:0] msg [16];

    int  cyc = 0;
    int  cfg_cnt = 0, done_cnt = 0, err_cnt = 0;
    int  err_cyc = 0, req_rise_cyc = 0;
    int  msg_out = 0, first_out_cyc = 0, last_out_cyc = 0;
    int  cfg_base = 0, done_base = 0;
    logic       req_prev = 1'b0;
    logic [5:0] sym_prev = 6'd0;

    int  ack_delay = 2;
    bit  never_ack = 1'b0;
    bit  spurious_en = 1'b1;
    int  wait_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference rotor: a fixed shift by 4 over the alphabet 1..26.
    function automatic logic [5:0] cipher(input logic [5:0] s);
        int v;
        v = int'(s);
        return 6'(((v - 1 + 4) % 26) + 1);
    endfunction

    function automatic bit letter(input logic [5:0] s);
        return (s >= 6'd1) && (s <= 6'd26);
    endfunction

    function automatic logic [5:0] ref_out(input logic [5:0] s);
        if (letter(s)) return cipher(s);
        return s;
    endfunction

    function automatic logic [31:0] outs_or();
        return 32'({bus.in_rdy_o, bus.cfg_load_o, bus.core_req_o, bus.core_sym_o,
                    bus.wrap_o, bus.out_vld_o, bus.busy_o, bus.done_o, bus.err_o});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every valid output and watches core requests.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            req_prev = 1'b0;
            sym_prev = 6'd0;
        end else begin
            if (bus.out_vld_o) begin
                if (exp_q.size() == 0) chk("unexpected_out", 32'(bus.wrap_o), 32'd999);
                else chk("wrap_o", 32'(bus.wrap_o), 32'(exp_q.pop_front()));
                if (msg_out == 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                msg_out++;
            end else begin
                chk("wrap_o_idle_zero", 32'(bus.wrap_o), 32'd0);
            end
            if (bus.cfg_load_o) cfg_cnt++;
            if (bus.done_o) done_cnt++;
            if (bus.err_o) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (bus.core_req_o && !req_prev) begin
                req_rise_cyc = cyc;
                if (let_q.size() == 0) chk("unexpected_core_req", 32'(bus.core_sym_o), 32'd999);
                else chk("core_sym_o", 32'(bus.core_sym_o), 32'(let_q.pop_front()));
            end else if (bus.core_req_o && req_prev) begin
                chk("core_sym_stable", 32'(bus.core_sym_o), 32'(sym_prev));
            end
            req_prev = bus.core_req_o;
            sym_prev = bus.core_sym_o;
        end
    end

    // Rotor-core responder: acks ack_delay cycles after a request with the reference cipher.
    initial begin
        bus.core_ack_i = 1'b0;
        bus.core_sym_i = 6'd0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.core_ack_i) begin
                bus.core_ack_i = 1'b0;
                bus.core_sym_i = 6'($urandom);
                wait_cnt = 0;
            end else if (bus.core_req_o && !never_ack) begin
                if (wait_cnt >= ack_delay) begin
                    bus.core_ack_i = 1'b1;
                    bus.core_sym_i = cipher(bus.core_sym_o);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (!bus.core_req_o && spurious_en && !never_ack && ($urandom_range(0, 7) == 0)) begin
                    bus.core_ack_i = 1'b1;
                    bus.core_sym_i = 6'($urandom);
                end
            end
        end
    end

    task automatic load_msg(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(ref_out(msg[i]));
            if (letter(msg[i])) let_q.push_back(msg[i]);
        end
        msg_out   = 0;
        cfg_base  = cfg_cnt;
        done_base = done_cnt;
        bus.symb_numb_i = 6'(n);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.symb_numb_i = 6'($urandom);
        chk("in_rdy_after_start", 32'(bus.in_rdy_o), 32'd1);
        chk("busy_after_start", 32'(bus.busy_o), 32'd1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                bus.in_vld_i = 1'b0;
                bus.wrap_i = 6'($urandom);
                tick();
            end
            chk("in_rdy_load", 32'(bus.in_rdy_o), 32'd1);
            bus.in_vld_i = 1'b1;
            bus.wrap_i = msg[i];
            tick();
        end
        bus.in_vld_i = 1'b1;
        bus.wrap_i = 6'($urandom);
        tick();
        chk("in_rdy_after_load", 32'(bus.in_rdy_o), 32'd0);
        bus.in_vld_i = 1'b0;
    endtask

    task automatic finish_msg(input int n);
        int b;
        b = 0;
        while (done_cnt == done_base && b < 1000) begin
            tick();
            b++;
        end
        tick();
        tick();
        chk("done_pulses", 32'(done_cnt - done_base), 32'd1);
        chk("cfg_load_pulses", 32'(cfg_cnt - cfg_base), 32'd1);
        chk("out_count", 32'(msg_out), 32'(n));
        chk("out_contiguous", 32'(last_out_cyc - first_out_cyc), 32'(n - 1));
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("core_reqs_all_seen", 32'(let_q.size()), 32'd0);
        chk("busy_after_done", 32'(bus.busy_o), 32'd0);
    endtask

    task automatic run_msg(input int n, input int gap_max, input int dly);
        ack_delay = dly;
        load_msg(n, gap_max);
        finish_msg(n);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        let_q.delete();
    endtask

    initial begin
        int b;
        int e0;
        int d0;
        int n;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.symb_numb_i = 6'd0;
        bus.wrap_i = 6'd0;
        bus.in_vld_i = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", outs_or(), 32'd0);
        rst = 1'b1;
        tick();
        chk("post_reset_outputs", outs_or(), 32'd0);

        // Letters 1,2,3 acked two cycles later with 5,6,7
        msg[0] = 6'd1; msg[1] = 6'd2; msg[2] = 6'd3;
        run_msg(3, 0, 2);

        // Mixed letters and pass-through symbols
        msg[0] = 6'd8; msg[1] = 6'd0; msg[2] = 6'd27; msg[3] = 6'd9;
        run_msg(4, 1, 1);

        // Illegal lengths 0 and 17
        for (int k = 0; k < 2; k++) begin
            e0 = err_cnt;
            bus.symb_numb_i = (k == 0) ? 6'd0 : 6'd17;
            bus.start_i = 1'b1;
            tick();
            bus.start_i = 1'b0;
            chk("len_err_pulse", 32'(bus.err_o), 32'd1);
            chk("len_err_busy", 32'(bus.busy_o), 32'd0);
            tick();
            chk("len_err_one_cycle", 32'(bus.err_o), 32'd0);
            chk("len_err_stays_idle", 32'(bus.busy_o | bus.in_rdy_o), 32'd0);
            tick();
            chk("len_err_count", 32'(err_cnt - e0), 32'd1);
        end

        // Abort wins over a legal start in the same cycle
        bus.symb_numb_i = 6'd3;
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("abort_over_start", outs_or(), 32'd0);

        // Watchdog: core never acknowledges
        never_ack = 1'b1;
        msg[0] = 6'd5; msg[1] = 6'd6;
        e0 = err_cnt;
        load_msg(2, 0);
        b = 0;
        while (err_cnt == e0 && b < 400) begin
            tick();
            b++;
        end
        chk("wdog_err", 32'(err_cnt - e0), 32'd1);
        chk("wdog_latency", 32'(err_cyc - req_rise_cyc), 32'd255);
        chk("wdog_idle", 32'(bus.busy_o | bus.core_req_o), 32'd0);
        tick();
        chk("wdog_err_one_cycle", 32'(err_cnt - e0), 32'd1);
        never_ack = 1'b0;
        clear_sb();

        // Abort during ENC, then a one-symbol message
        msg[0] = 6'd20; msg[1] = 6'd21; msg[2] = 6'd22;
        e0 = err_cnt;
        d0 = done_cnt;
        ack_delay = 5;
        load_msg(3, 0);
        b = 0;
        while (!bus.core_req_o && b < 20) begin
            tick();
            b++;
        end
        chk("enc_req_seen", 32'(bus.core_req_o), 32'd1);
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        chk("abort_outputs", outs_or(), 32'd0);
        repeat (3) tick();
        chk("abort_no_err_done", 32'((err_cnt - e0) + (done_cnt - d0)), 32'd0);
        clear_sb();
        msg[0] = 6'd26;
        run_msg(1, 0, 0);

        // Reset low during DRAIN, then a one-symbol message
        msg[0] = 6'd3; msg[1] = 6'd40; msg[2] = 6'd11; msg[3] = 6'd12; msg[4] = 6'd63;
        load_msg(5, 0);
        b = 0;
        while (!bus.out_vld_o && b < 200) begin
            tick();
            b++;
        end
        chk("drain_seen", 32'(bus.out_vld_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("reset_mid_drain", outs_or(), 32'd0);
        clear_sb();
        tick();
        rst = 1'b1;
        tick();
        chk("after_reset_idle", outs_or(), 32'd0);
        msg[0] = 6'd0;
        run_msg(1, 0, 1);

        // Full depth with input gaps
        for (int i = 0; i < 16; i++) msg[i] = 6'($urandom);
        run_msg(16, 3, 1);

        // Random messages
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) msg[i] = 6'($urandom);
            run_msg(n, 2, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
